// File: rtl/heart_hit_detector.sv
// Heart/bullet collision detector: per-frame damage, invulnerability frames with
// heart blinking, and game-over flag for the player HP.
module heart_hit_detector #(
    parameter int NUM_BULLETS = 4,
    parameter int HP_INIT     = 20,
    parameter int DAMAGE      = 3,
    parameter int IFRAMES     = 30,
    parameter int FIGHT_STATE = 1,
    parameter int LAST_X      = 639,
    parameter int LAST_Y      = 479
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             state,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   heartSpriteOn,
    input  logic [NUM_BULLETS-1:0] bulletSpriteOn,
    input  logic                   restart,
    output logic [7:0]             hp,
    output logic                   hit_pulse,
    output logic                   invuln,
    output logic                   heart_visible,
    output logic                   game_over
);

    // state      | meaning
    // ST_ARMED   | hits are applied at the frame evaluation
    // ST_INVULN  | hits ignored; iframe counter runs down once per frame
    // ST_DEAD    | hp is 0, evaluations ignored until restart
    localparam logic [1:0] ST_ARMED  = 2'd0;
    localparam logic [1:0] ST_INVULN = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam int         IW      = $clog2(IFRAMES + 1);
    localparam logic [7:0] HP_LOAD = 8'(HP_INIT);
    localparam logic [7:0] DMG     = 8'(DAMAGE);

    logic [1:0]    fsm_q, fsm_next;
    logic [7:0]    hp_q, hp_next;
    logic [IW-1:0] ifr_q, ifr_next;
    logic [2:0]    blink_q, blink_next;
    logic          flag_q, flag_next;
    logic          pulse_q, pulse_next;
    logic          eof_q;

    logic          ov;
    logic          fight;
    logic          eof_now;
    logic          eval_now;
    logic          hit;
    logic [7:0]    hp_after_hit;

    assign ov       = heartSpriteOn & (|bulletSpriteOn);
    assign fight    = (state == 4'(FIGHT_STATE));
    assign eof_now  = (x == 10'(LAST_X)) && (y == 10'(LAST_Y));
    // Coordinates can sit on the last pixel for several clocks; only the first counts.
    assign eval_now = fight & eof_now & ~eof_q;
    assign hit      = flag_q | ov;

    assign hp_after_hit = (hp_q > DMG) ? (hp_q - DMG) : 8'd0;

    always_comb begin
        fsm_next   = fsm_q;
        hp_next    = hp_q;
        ifr_next   = ifr_q;
        blink_next = blink_q;
        flag_next  = flag_q;
        pulse_next = 1'b0;

        if (restart) begin
            fsm_next   = ST_ARMED;
            hp_next    = HP_LOAD;
            ifr_next   = '0;
            blink_next = '0;
            flag_next  = 1'b0;
        end else if (eval_now) begin
            flag_next = 1'b0;
            case (fsm_q)
                ST_ARMED: begin
                    if (hit) begin
                        hp_next    = hp_after_hit;
                        pulse_next = 1'b1;
                        if (hp_after_hit == 8'd0) begin
                            fsm_next = ST_DEAD;
                        end else begin
                            fsm_next   = ST_INVULN;
                            ifr_next   = IW'(IFRAMES);
                            blink_next = '0;
                        end
                    end
                end
                ST_INVULN: begin
                    ifr_next   = ifr_q - IW'(1);
                    blink_next = blink_q + 3'd1;
                    if (ifr_q == IW'(1)) begin
                        fsm_next = ST_ARMED;
                    end
                end
                ST_DEAD: begin
                    hp_next = 8'd0;
                end
                default: begin
                    fsm_next = ST_ARMED;
                end
            endcase
        end else begin
            flag_next = fight & (flag_q | ov);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_ARMED;
            hp_q    <= HP_LOAD;
            ifr_q   <= '0;
            blink_q <= '0;
            flag_q  <= 1'b0;
            pulse_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_next;
            hp_q    <= hp_next;
            ifr_q   <= ifr_next;
            blink_q <= blink_next;
            flag_q  <= flag_next;
            pulse_q <= pulse_next;
            eof_q   <= eof_now;
        end
    end

    assign hp            = hp_q;
    assign hit_pulse     = pulse_q;
    assign invuln        = (fsm_q == ST_INVULN);
    assign game_over     = (fsm_q == ST_DEAD);
    // Blink: visible for four evaluations, hidden for four, starting visible.
    assign heart_visible = (fsm_q != ST_INVULN) | ~blink_q[2];

endmodule

// File: doc/heart_hit_detector.md
Name: heart_hit_detector

Overview:
- Consumer of the per-pixel sprite-on flags produced by the bullet sprite blocks and the heart (player) sprite block.
- Detects pixel overlap between the heart and any bullet during each scanned frame. Once per frame it applies damage to the player HP, runs invulnerability frames with heart blinking, and flags game over.
- Sits between the sprite generators and the game-state controller / HP bar renderer.

Parameters:
- NUM_BULLETS, 4, number of bullet sprite-on inputs.
- HP_INIT, 20, HP loaded at reset and on restart.
- DAMAGE, 3, HP removed per registered hit.
- IFRAMES, 30, frames of invulnerability after a hit.
- FIGHT_STATE, 1, value of state in which collisions are live.
- LAST_X, 639, x of last visible pixel.
- LAST_Y, 479, y of last visible pixel.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- state  input  4  game state from the controller.
- x  input  10  current scan x.
- y  input  10  current scan y.
- heartSpriteOn  input  1  heart sprite covers the current pixel.
- bulletSpriteOn  input  NUM_BULLETS  bit i: bullet i covers the current pixel.
- restart  input  1  single-cycle pulse; reload HP and re-arm.
- hp  output  8  current HP.
- hit_pulse  output  1  one-cycle pulse when damage is applied.
- invuln  output  1  high while in the INVULN state.
- heart_visible  output  1  heart draw enable (blink gating).
- game_over  output  1  high in the DEAD state.

Behaviour:
- Reset (rst_n=0, async): hp=HP_INIT, FSM=ARMED, frame flag=0, iframe counter=0, blink counter=0, hit_pulse=0, invuln=0, heart_visible=1, game_over=0.
- Overlap per clk: ov = heartSpriteOn & (|bulletSpriteOn).
- Collision flag: set on any clk with state==FIGHT_STATE and ov=1. Cleared on every frame evaluation and on any clk with state!=FIGHT_STATE.
- End-of-frame (eof): x==LAST_X and y==LAST_Y. Coordinates may hold for several clk, so evaluation happens only on the first clk of eof (rising-edge detect on the registered eof compare). Exactly one evaluation per frame.
- Evaluation only when state==FIGHT_STATE. Otherwise the FSM, hp and counters hold; hit_pulse=0.
- hit = collision flag OR ov on the evaluation clk.
- FSM states: ARMED, INVULN, DEAD.
  - ARMED, hit: hp <= (hp>DAMAGE) ? hp-DAMAGE : 0, saturating and never wrapping. hit_pulse=1 on the next clk for exactly 1 clk.
    - New hp==0: go to DEAD.
    - Otherwise: go to INVULN with iframe counter=IFRAMES.
  - ARMED, no hit: stay.
  - INVULN: hits ignored, no damage. Each evaluation decrements the iframe counter. The evaluation that brings it from 1 to 0 returns to ARMED. A collision in that same frame is not applied; the flag is cleared.
  - DEAD: game_over=1; hp holds 0; evaluations ignored.
- Registered outputs: invuln=1 iff FSM==INVULN.
- heart_visible:
  - 1 in ARMED and DEAD.
  - In INVULN: a 3-bit blink counter increments per evaluation, and heart_visible = ~blink[2] (toggles every 4 frames, starting visible).
  - Blink counter clears on entry to INVULN.
- restart pulse, any state, priority over evaluation on the same clk: hp=HP_INIT, FSM=ARMED, counters and flag cleared, game_over=0, hit_pulse=0.
- Reset asserted mid-frame or mid-INVULN: immediate return to reset values.
- Only the most recent hit per frame counts. Multiple overlapping bullets in one frame cost DAMAGE once.

Test Plan:
- State=1, heart and bullet0 overlap for 6 pixels mid-frame, eof held 4 clk -> one hit_pulse, hp 20->17, invuln=1, counter=30.
- Same overlap each frame for 31 frames after the hit -> no further damage during 30 INVULN evaluations. heart_visible pattern is 1111 0000 repeating. ARMED after 30th evaluation. Hit at 32nd eof -> hp 17->14.
- hp=2, DAMAGE=3, hit -> hp=0 (no wrap), game_over=1 next clk. Further overlaps and evaluations -> hp stays 0, no hit_pulse.
- state=0 with overlap during frame, state=1 by eof -> no hit (flag cleared outside fight), hp unchanged.
- restart and a hit evaluation on the same clk while DEAD -> hp=20, ARMED, game_over=0, hit_pulse=0.
- rst_n pulsed low mid-INVULN (counter=12) -> immediately hp=20, invuln=0, heart_visible=1, no hit_pulse after release.
